xkeybuf: RTL and testbench

Buffered PS/2 keyboard front end for the controller data bus. It deserialises raw `ps2_clk`/`ps2_data` frames and folds the E0 (extended) and F0 (break) prefixes into single key events. Events are queued in a small FIFO that the controller drains through a memory-mapped read port, so no scancode is lost while the program is busy with the display or the push buttons. It sits between the keyboard pins and the top-level address decoder, at one data-bus address.

---
 rtl/xkeybuf_pkg.sv | 29 ++
 rtl/xkeybuf_rx.sv | 120 ++++++++++++
 rtl/xkeybuf.sv | 115 +++++++++++
 tb/tb_xkeybuf.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xkeybuf_pkg.sv
// Shared constants and types for the buffered PS/2 keyboard front end.
// Build option: XKEYBUF_PARITY_EN turns on the odd-parity check in xps2_rx.
package xkeybuf_pkg;

  localparam logic [7:0] KB_E0 = 8'hE0;
  localparam logic [7:0] KB_F0 = 8'hF0;

  localparam int ENTRY_W = 10;
  localparam int DOUT_W  = 13;

  // data_out = {frame_err, ovf, valid, ext, brk, code[7:0]}
  localparam int DO_CODE_LSB = 0;
  localparam int DO_BRK      = 8;
  localparam int DO_EXT      = 9;
  localparam int DO_VALID    = 10;
  localparam int DO_OVF      = 11;
  localparam int DO_FERR     = 12;

  localparam logic [15:0] KBUF_BASE = 16'hFF10;

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_DONE} rx_state_t;
  typedef enum logic [1:0] {DEC_IDLE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic ext, input logic brk,
                                                     input logic [7:0] code);
    return {ext, brk, code};
  endfunction

endpackage

// File: rtl/xkeybuf_rx.sv
// PS/2 receiver: synchronisers, clock glitch filter, falling-edge strobe, frame FSM.
// Build option: XKEYBUF_PARITY_EN enables the odd-parity check.
module xps2_rx
  import xkeybuf_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_vld,
  output logic [7:0] data_byte,
  output logic       frame_err_pulse
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          fall;
  rx_state_t     state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] idle_cnt;
  logic          parity_ok;
  logic          frame_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // A level change is accepted only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

`ifdef XKEYBUF_PARITY_EN
  assign parity_ok = ^{shreg, parity_bit};
`else
  logic unused_parity;
  assign unused_parity = parity_bit;
  assign parity_ok     = 1'b1;
`endif

  // On the stop-bit edge the incoming sample is the stop bit itself.
  assign frame_ok = data_sync[1] & parity_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RX_IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      parity_bit      <= 1'b0;
      idle_cnt        <= '0;
      byte_vld        <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_vld        <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          idle_cnt <= '0;
          bit_cnt  <= 4'd1;
          if (fall && !data_sync[1]) state <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (fall) begin
            idle_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt <= 4'd8) begin
              shreg <= {data_sync[1], shreg[7:1]};
            end else if (bit_cnt == 4'd9) begin
              parity_bit <= data_sync[1];
            end else begin
              state           <= RX_DONE;
              byte_vld        <= frame_ok;
              frame_err_pulse <= ~frame_ok;
            end
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            state <= RX_IDLE;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        RX_DONE: state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign data_byte = shreg;

endmodule

// File: rtl/xkeybuf.sv
// Buffered PS/2 keyboard port: prefix decoder folding E0/F0 into events, event FIFO, bus port.
// Build option: XKEYBUF_PARITY_EN (passed through to xps2_rx) enables the parity check.
module xkeybuf
  import xkeybuf_pkg::*;
#(
  parameter int FIFO_AW  = 3,
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        data_in,
  output logic [DOUT_W-1:0] data_out
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic               byte_vld;
  logic [7:0]         data_byte;
  logic               frame_err_pulse;
  dec_state_t         dec_state;
  logic               flush;
  logic               clear;
  logic               rd;
  logic               ext;
  logic               brk;
  logic               push;
  logic               push_ok;
  logic               pop;
  logic               empty;
  logic               full;
  logic [FIFO_AW:0]   wptr;
  logic [FIFO_AW:0]   rptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               frame_err;
  logic               ovf;

  xps2_rx #(
    .FILT_LEN(FILT_LEN),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .byte_vld       (byte_vld),
    .data_byte      (data_byte),
    .frame_err_pulse(frame_err_pulse)
  );

  assign flush = sel & we & data_in[0];
  assign clear = sel & we & data_in[1];
  assign rd    = sel & ~we;

  assign ext  = (dec_state == DEC_E0) || (dec_state == DEC_E0F0);
  assign brk  = (dec_state == DEC_F0) || (dec_state == DEC_E0F0);
  // A flush in the same cycle discards the incoming event.
  assign push = byte_vld && (data_byte != KB_E0) && (data_byte != KB_F0) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state <= DEC_IDLE;
    end else if (flush) begin
      dec_state <= DEC_IDLE;
    end else if (byte_vld) begin
      case (data_byte)
        KB_E0:   dec_state <= DEC_E0;
        KB_F0:   dec_state <= ext ? DEC_E0F0 : DEC_F0;
        default: dec_state <= DEC_IDLE;
      endcase
    end
  end

  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign push_ok = push & ~full;
  assign pop     = rd & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= make_entry(ext, brk, data_byte);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (FIFO_AW + 1)'(1);
      if (pop)     rptr <= rptr + (FIFO_AW + 1)'(1);
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (frame_err_pulse)  frame_err <= 1'b1;
      else if (clear)       frame_err <= 1'b0;
      if (push && full)     ovf <= 1'b1;
      else if (clear)       ovf <= 1'b0;
    end
  end

  assign head     = empty ? '0 : mem[rptr[FIFO_AW-1:0]];
  assign data_out = {frame_err, ovf, ~empty, head};

endmodule

// File: tb/tb_xkeybuf.sv
// Directed self-checking bench for xkeybuf; parity expectations follow XKEYBUF_PARITY_EN.
module tb_xkeybuf;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        sel;
  logic        we;
  logic [1:0]  data_in;
  logic [12:0] data_out;
  int          passed = 0;
  int          total  = 0;

  xkeybuf #(
    .FIFO_AW (3),
    .FILT_LEN(8),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .sel     (sel),
    .we      (we),
    .data_in (data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    idle(10);
    ps2_clk = 1'b0;
    idle(20);
    ps2_clk = 1'b1;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_code(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
    idle(20);
  endtask

  task automatic bus_read(output logic [12:0] v);
    @(negedge clk);
    sel = 1'b1;
    we  = 1'b0;
    #1 v = data_out;
    @(posedge clk);
    #1 sel = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] v);
    @(negedge clk);
    sel     = 1'b1;
    we      = 1'b1;
    data_in = v;
    @(posedge clk);
    #1;
    sel     = 1'b0;
    we      = 1'b0;
    data_in = 2'b00;
  endtask

  task automatic wait_byte_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dut.u_rx.byte_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(2);
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL reset: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] v;
    send_frame(8'h55, 1'b0, 1'b0, 5);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    send_code(8'h2B);
    bus_read(v);
    total++;
    if (v !== 13'h42B) $display("[TB] FAIL reset_mid_frame: got %h expected %h", v, 13'h42B);
    else passed++;
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL reset_mid_frame_empty: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_single_make();
    logic [12:0] v;
    send_code(8'h1C);
    bus_read(v);
    total++;
    if (v !== 13'h41C) $display("[TB] FAIL single_make: got %h expected %h", v, 13'h41C);
    else passed++;
    bus_read(v);
    total++;
    if (v !== 13'h000) $display("[TB] FAIL single_make_empty: got %h expected %h", v, 13'h000);
    else passed++;
  endtask

  task automatic test_ext_break();
    logic [12:0] v;
    send_code(8'hE0);
    send_code(8'hF0);
    send_code(8'h74);
    bus_read(v);
    total++;
    if (v !== 13'h774) $display("[TB] FAIL ext_break: got %h expected %h", v, 13'h774);
    else passed++;
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL ext_break_single: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [12:0] v;
    logic [12:0] exp;
    for (int i = 0; i < 9; i++) send_code(8'h10 + 8'(i));
    total++;
    if (data_out !== 13'hC10) $display("[TB] FAIL overflow_status: got %h expected %h", data_out, 13'hC10);
    else passed++;
    bus_write(2'b10);
    total++;
    if (data_out !== 13'h410) $display("[TB] FAIL overflow_clear: got %h expected %h", data_out, 13'h410);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      bus_read(v);
      exp = 13'h410 + 13'(i);
      total++;
      if (v !== exp) $display("[TB] FAIL overflow_entry%0d: got %h expected %h", i, v, exp);
      else passed++;
    end
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL overflow_drained: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_frame_errors();
    logic [12:0] v;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    idle(20);
`ifdef XKEYBUF_PARITY_EN
    total++;
    if (data_out !== 13'h1000) $display("[TB] FAIL parity_err: got %h expected %h", data_out, 13'h1000);
    else passed++;
    bus_write(2'b10);
    v = data_out;
`else
    bus_read(v);
    total++;
    if (v !== 13'h41C) $display("[TB] FAIL parity_ignored: got %h expected %h", v, 13'h41C);
    else passed++;
    v = data_out;
`endif
    total++;
    if (v !== 13'h000) $display("[TB] FAIL parity_after: got %h expected %h", v, 13'h000);
    else passed++;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    idle(20);
    total++;
    if (data_out !== 13'h1000) $display("[TB] FAIL stop_err: got %h expected %h", data_out, 13'h1000);
    else passed++;
    bus_write(2'b10);
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL stop_err_clear: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_truncated();
    logic [12:0] v;
    send_frame(8'hFF, 1'b0, 1'b0, 6);
    idle(TO + 100);
    send_code(8'h2A);
    bus_read(v);
    total++;
    if (v !== 13'h42A) $display("[TB] FAIL truncated: got %h expected %h", v, 13'h42A);
    else passed++;
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL truncated_after: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [12:0] v;
    logic [12:0] exp;
    send_code(8'h01);
    send_code(8'h02);
    send_code(8'h03);
    @(negedge clk);
    sel = 1'b1;
    we  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 v = data_out;
      exp = 13'h401 + 13'(k);
      total++;
      if (v !== exp) $display("[TB] FAIL back_to_back%0d: got %h expected %h", k, v, exp);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL back_to_back_empty: got %h expected %h", data_out, 13'h000);
    else passed++;
    sel = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [12:0] v;
    bit ok;
    v = '0;
    send_code(8'h1C);
    fork
      send_frame(8'h33, 1'b0, 1'b0, 11);
      begin
        wait_byte_vld(ok);
        if (ok) begin
          sel = 1'b1;
          we  = 1'b0;
          #1 v = data_out;
          @(posedge clk);
          #1 sel = 1'b0;
        end
      end
    join
    idle(20);
    total++;
    if (!ok) $display("[TB] FAIL push_pop_timeout: got %0d expected %0d", ok, 1);
    else passed++;
    total++;
    if (v !== 13'h41C) $display("[TB] FAIL push_pop_read: got %h expected %h", v, 13'h41C);
    else passed++;
    bus_read(v);
    total++;
    if (v !== 13'h433) $display("[TB] FAIL push_pop_head: got %h expected %h", v, 13'h433);
    else passed++;
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL push_pop_count: got %h expected %h", data_out, 13'h000);
    else passed++;

    send_code(8'h1C);
    fork
      send_frame(8'h44, 1'b0, 1'b0, 11);
      begin
        wait_byte_vld(ok);
        if (ok) begin
          sel     = 1'b1;
          we      = 1'b1;
          data_in = 2'b01;
          @(posedge clk);
          #1;
          sel     = 1'b0;
          we      = 1'b0;
          data_in = 2'b00;
        end
      end
    join
    idle(20);
    total++;
    if (!ok) $display("[TB] FAIL flush_push_timeout: got %0d expected %0d", ok, 1);
    else passed++;
    total++;
    if (data_out !== 13'h000) $display("[TB] FAIL flush_push: got %h expected %h", data_out, 13'h000);
    else passed++;
  endtask

  task automatic test_flush_decoder();
    logic [12:0] v;
    send_code(8'hE0);
    bus_write(2'b01);
    send_code(8'h22);
    bus_read(v);
    total++;
    if (v !== 13'h422) $display("[TB] FAIL flush_decoder: got %h expected %h", v, 13'h422);
    else passed++;
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    sel      = 1'b0;
    we       = 1'b0;
    data_in  = 2'b00;
    test_reset();
    test_reset_mid_frame();
    test_single_make();
    test_ext_break();
    test_overflow();
    test_frame_errors();
    test_truncated();
    test_back_to_back();
    test_simultaneous();
    test_flush_decoder();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
